// File: rtl/bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, BCD digit width and the double-dabble add-3 rule.
package bcd_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } bcd_state_t;

    localparam int BCD_DIGIT_W = 4;

    // A digit of 5 or more is pre-corrected by 3 so that the following
    // left shift (x2) carries cleanly into the next decimal digit.
    function automatic logic [BCD_DIGIT_W-1:0] bcd_adj(input logic [BCD_DIGIT_W-1:0] digit);
        logic [BCD_DIGIT_W-1:0] result;
        result = digit;
        if (digit >= 4'd5) begin
            result = digit + 4'd3;
        end
        return result;
    endfunction

endpackage

// File: rtl/seq_bin2bcd_if.sv
// Handshake bundle between the binary source (register-file/PC tap) and the
// converter, plus the result channel towards the 7-segment driver.
// master: producer of in_* / consumer of out_*; slave: the converter itself.
interface seq_bin2bcd_if
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
) ();

    logic                          in_valid;
    logic                          in_ready;
    logic [BIN_W-1:0]              in_bin;
    logic                          out_valid;
    logic                          out_ready;
    logic [BCD_DIGIT_W*DIGITS-1:0] out_bcd;
    logic                          out_ovf;
    logic                          out_neg;

    modport master (
        output in_valid,
        output in_bin,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_bcd,
        input  out_ovf,
        input  out_neg
    );

    modport slave (
        input  in_valid,
        input  in_bin,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_bcd,
        output out_ovf,
        output out_neg
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Combinational add-3 correction for a single BCD digit (one per digit slot).
module bcd_digit_adj
    import bcd_pkg::*;
(
    input  logic [BCD_DIGIT_W-1:0] digit_i,
    output logic [BCD_DIGIT_W-1:0] digit_o
);

    assign digit_o = bcd_adj(digit_i);

endmodule

// File: rtl/seq_bin2bcd.sv
// Sequential binary-to-BCD converter using double-dabble, one bit per clock.
// A value is accepted in IDLE, shifted through the digit chain for BIN_W
// cycles in SHIFT, and presented in DONE until the consumer takes it.
// Optional feature macro: SIGNED_INPUT_EN -- treats in_bin as two's
// complement, converts its magnitude and reports the sign on out_neg.
// Without it in_bin is unsigned and out_neg is tied low.
module seq_bin2bcd
    import bcd_pkg::*;
#(
    parameter int BIN_W  = 13,
    parameter int DIGITS = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    seq_bin2bcd_if.slave  bus
);

    localparam int CNT_W = $clog2(BIN_W) + 1;
    localparam int BCD_W = BCD_DIGIT_W * DIGITS;

    bcd_state_t       state_q, state_d;
    logic [BIN_W-1:0] shiftReg_q, shiftReg_d;
    logic [BCD_W-1:0] digits_q, digits_d;
    logic [BCD_W-1:0] adjDigits;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             ovf_q, ovf_d;
    logic             accept;
    logic [BIN_W-1:0] loadValue;

    // Every digit gets its add-3 correction in parallel before each shift.
    for (genvar g = 0; g < DIGITS; g++) begin : gDigitAdj
        bcd_digit_adj uDigitAdj (
            .digit_i (digits_q[g*BCD_DIGIT_W +: BCD_DIGIT_W]),
            .digit_o (adjDigits[g*BCD_DIGIT_W +: BCD_DIGIT_W])
        );
    end

    // The ready output is masked by reset so no source sees a ready converter
    // while it is being held in reset.
    assign accept        = bus.in_valid && bus.in_ready;
    assign bus.in_ready  = (state_q == IDLE) && rst_n;
    assign bus.out_valid = (state_q == DONE);
    assign bus.out_bcd   = digits_q;
    assign bus.out_ovf   = ovf_q;

`ifdef SIGNED_INPUT_EN
    logic neg_q, neg_d;
    logic loadNeg;

    // Negative inputs are loaded as their magnitude; the most-negative value
    // maps onto 2^(BIN_W-1), which still fits the unsigned shift register.
    always_comb begin
        loadNeg   = bus.in_bin[BIN_W-1];
        loadValue = bus.in_bin;
        if (loadNeg) begin
            loadValue = ~bus.in_bin + BIN_W'(1);
        end
    end

    assign bus.out_neg = neg_q;
`else
    // Unsigned build: the input goes straight into the shift register.
    always_comb begin
        loadValue = bus.in_bin;
    end

    assign bus.out_neg = 1'b0;
`endif

    // Next-state logic: accept in IDLE, one double-dabble step per SHIFT
    // cycle, hold the result in DONE until the consumer is ready.
    always_comb begin
        state_d    = state_q;
        shiftReg_d = shiftReg_q;
        digits_d   = digits_q;
        cnt_d      = cnt_q;
        ovf_d      = ovf_q;
`ifdef SIGNED_INPUT_EN
        neg_d      = neg_q;
`endif

        case (state_q)
            IDLE: begin
                if (accept) begin
                    shiftReg_d = loadValue;
                    digits_d   = '0;
                    ovf_d      = 1'b0;
                    cnt_d      = CNT_W'(BIN_W - 1);
`ifdef SIGNED_INPUT_EN
                    neg_d      = loadNeg;
`endif
                    state_d    = SHIFT;
                end
            end

            SHIFT: begin
                // The top bit of the corrected top digit is the carry that
                // falls off the chain; once lost the result no longer fits.
                ovf_d      = ovf_q | adjDigits[BCD_W-1];
                digits_d   = {adjDigits[BCD_W-2:0], shiftReg_q[BIN_W-1]};
                shiftReg_d = shiftReg_q << 1;
                if (cnt_q == '0) begin
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end

            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset aborts any conversion in flight
    // and clears every visible output.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            shiftReg_q <= '0;
            digits_q   <= '0;
            cnt_q      <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            shiftReg_q <= shiftReg_d;
            digits_q   <= digits_d;
            cnt_q      <= cnt_d;
            ovf_q      <= ovf_d;
        end
    end

`ifdef SIGNED_INPUT_EN
    // Sign flag is captured alongside the magnitude on the accepting edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            neg_q <= 1'b0;
        end else begin
            neg_q <= neg_d;
        end
    end
`endif

endmodule
